// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, drives the ROM address and queues {pc, instr} pairs for the decoder.
// Define IFQ_STATS_EN to build the stall/flush statistics counters; otherwise they read 0.
module ifetch_queue #(
    parameter int ADDR_WIDTH  = 5,
    parameter int INSTR_WIDTH = 8,
    parameter int DEPTH       = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_WIDTH-1:0]      rom_addr,
    input  logic [INSTR_WIDTH-1:0]     rom_data,
    input  logic                       jump_en,
    input  logic [ADDR_WIDTH-1:0]      jump_target,
    input  logic                       instr_ready,
    output logic                       instr_valid,
    output logic [INSTR_WIDTH-1:0]     instr,
    output logic [ADDR_WIDTH-1:0]      instr_pc,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 stall_cnt,
    output logic [7:0]                 flush_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        pop   = !empty && instr_ready;
        // A full queue may still accept a fetch when the head leaves in the same cycle.
        push  = !jump_en && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= ADDR_WIDTH'(RESET_PC);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (jump_en) begin
            fetch_pc <= jump_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem[wr_ptr] <= rom_data;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    always_comb begin
        rom_addr    = fetch_pc;
        instr_valid = !empty;
        level       = count;
        instr       = '0;
        instr_pc    = '0;
        if (!empty) begin
            instr    = instr_mem[rd_ptr];
            instr_pc = pc_mem[rd_ptr];
        end
    end

`ifdef IFQ_STATS_EN
    logic [7:0] stall_q;
    logic [7:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!empty && !instr_ready && !jump_en && stall_q != '1) begin
                stall_q <= stall_q + 8'd1;
            end
            if (jump_en && flush_q != '1) begin
                flush_q <= flush_q + 8'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ifetch_queue;

`ifdef IFQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rom_addr, rom_addr2;
    logic [7:0] rom_data, rom_data2;
    logic       jump_en = 1'b0;
    logic [4:0] jump_target = '0;
    logic       instr_ready = 1'b0;
    logic       instr_valid, instr_valid2;
    logic [7:0] instr, instr2;
    logic [4:0] instr_pc, instr_pc2;
    logic [2:0] level, level2;
    logic [7:0] stall_cnt, stall_cnt2, flush_cnt, flush_cnt2;

    logic [7:0] rom [32];

    int checks = 0;
    int failures = 0;

    // Reference model: queue of accepted {pc, instr} pairs and the fetch pointer.
    logic [12:0] q [$];
    int m_pc;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom[rom_addr2];

    ifetch_queue #(.ADDR_WIDTH(5), .INSTR_WIDTH(8), .DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .jump_en(jump_en), .jump_target(jump_target), .instr_ready(instr_ready),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .level(level),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ifetch_queue #(.ADDR_WIDTH(5), .INSTR_WIDTH(8), .DEPTH(4), .RESET_PC(30)) dut_wrap (
        .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .jump_en(1'b0), .jump_target(5'd0), .instr_ready(1'b1),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .level(level2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    function automatic logic [7:0] exp_instr();
        return (q.size() != 0) ? q[0][7:0] : 8'd0;
    endfunction

    function automatic logic [4:0] exp_pc();
        return (q.size() != 0) ? q[0][12:8] : 5'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_edge(input logic j, input logic [4:0] t, input logic r);
        bit pop, push;
        pop  = (q.size() != 0) && r;
        push = !j && ((q.size() < 4) || pop);
        if (STATS && q.size() != 0 && !r && !j && m_stall < 255) m_stall++;
        if (STATS && j && m_flush < 255) m_flush++;
        if (j) begin
            q.delete();
            m_pc = t;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({5'(m_pc), rom[m_pc]});
                m_pc = (m_pc + 1) % 32;
            end
        end
    endtask

    // Drive one clock with the given inputs; returns 1 time unit after the edge.
    task automatic cycle(input logic j, input logic [4:0] t, input logic r);
        jump_en = j;
        jump_target = t;
        instr_ready = r;
        model_edge(j, t, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        jump_en = 1'b0;
        instr_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", instr_valid); end
        checks++; if (instr !== 8'd0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", instr); end
        checks++; if (instr_pc !== 5'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", instr_pc); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (rom_addr !== 5'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_stream();
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 5'd0, 1'b1);
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%0d exp=1", k, instr_valid); end
            checks++; if (instr !== 8'(8'h10 + k)) begin failures++; $display("FAIL stream_instr k=%0d got=%0h exp=%0h", k, instr, 8'h10 + k); end
            checks++; if (instr_pc !== 5'(k)) begin failures++; $display("FAIL stream_pc k=%0d got=%0d exp=%0d", k, instr_pc, k); end
            checks++; if (level > 3'd1) begin failures++; $display("FAIL stream_level k=%0d got=%0d exp<=1", k, level); end
        end
    endtask

    task automatic test_stall();
        int got [$];
        do_reset(1);
        repeat (10) cycle(1'b0, 5'd0, 1'b0);
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL stall_level got=%0d exp=4", level); end
        checks++; if (rom_addr !== 5'd4) begin failures++; $display("FAIL stall_rom_addr got=%0d exp=4", rom_addr); end
        for (int k = 0; k < 8; k++) begin
            if (instr_valid === 1'b1) got.push_back(int'(instr_pc));
            cycle(1'b0, 5'd0, 1'b1);
        end
        checks++; if (got.size() != 8) begin failures++; $display("FAIL drain_count got=%0d exp=8", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] != k) begin failures++; $display("FAIL drain_order idx=%0d got=%0d exp=%0d", k, got[k], k); end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_pcs [4];
        logic [4:0] exp_addr [4];
        exp_pcs[0] = 5'd30; exp_pcs[1] = 5'd31; exp_pcs[2] = 5'd0; exp_pcs[3] = 5'd1;
        exp_addr[0] = 5'd31; exp_addr[1] = 5'd0; exp_addr[2] = 5'd1; exp_addr[3] = 5'd2;
        do_reset(1);
        checks++; if (rom_addr2 !== 5'd30 || instr_valid2 !== 1'b0) begin failures++; $display("FAIL wrap_reset got addr=%0d valid=%0d exp addr=30 valid=0", rom_addr2, instr_valid2); end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 5'd0, 1'b1);
            checks++; if (instr_pc2 !== exp_pcs[k] || instr2 !== rom[exp_pcs[k]]) begin failures++; $display("FAIL wrap_pc k=%0d got=%0d/%0h exp=%0d/%0h", k, instr_pc2, instr2, exp_pcs[k], rom[exp_pcs[k]]); end
            checks++; if (rom_addr2 !== exp_addr[k]) begin failures++; $display("FAIL wrap_rom_addr k=%0d got=%0d exp=%0d", k, rom_addr2, exp_addr[k]); end
        end
        checks++; if (stall_cnt2 !== 8'd0 || flush_cnt2 !== 8'd0 || level2 > 3'd1) begin failures++; $display("FAIL wrap_misc got stats=%0d/%0d level=%0d exp 0/0 <=1", stall_cnt2, flush_cnt2, level2); end
    endtask

    task automatic test_jump_full();
        do_reset(1);
        repeat (6) cycle(1'b0, 5'd0, 1'b0);
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL jump_prefull got=%0d exp=4", level); end
        cycle(1'b1, 5'd9, 1'b1);
        checks++; if (instr_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL jump_flush got valid=%0d level=%0d exp 0/0", instr_valid, level); end
        checks++; if (rom_addr !== 5'd9) begin failures++; $display("FAIL jump_rom_addr got=%0d exp=9", rom_addr); end
        cycle(1'b0, 5'd0, 1'b0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd9 || instr !== rom[9]) begin failures++; $display("FAIL jump_head got v=%0d pc=%0d i=%0h exp 1/9/%0h", instr_valid, instr_pc, instr, rom[9]); end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        repeat (3) cycle(1'b0, 5'd0, 1'b0);
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL mid_prelevel got=%0d exp=3", level); end
        do_reset(1);
        checks++; if (level !== 3'd0 || instr_valid !== 1'b0 || instr !== 8'd0) begin failures++; $display("FAIL mid_reset got level=%0d valid=%0d instr=%0h exp 0/0/0", level, instr_valid, instr); end
        checks++; if (rom_addr !== 5'd0) begin failures++; $display("FAIL mid_rom_addr got=%0d exp=0", rom_addr); end
        cycle(1'b0, 5'd0, 1'b1);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr !== rom[0]) begin failures++; $display("FAIL mid_restart got v=%0d pc=%0d i=%0h exp 1/0/%0h", instr_valid, instr_pc, instr, rom[0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        do_reset(1);
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 9) == 0), 5'($urandom), ($urandom_range(0, 2) != 0));
            checks++; if (instr_valid !== (q.size() != 0)) begin failures++; $display("FAIL rand_valid n=%0d got=%0d exp=%0d", n, instr_valid, q.size() != 0); end
            checks++; if (instr !== exp_instr() || instr_pc !== exp_pc()) begin failures++; $display("FAIL rand_head n=%0d got=%0d/%0h exp=%0d/%0h", n, instr_pc, instr, exp_pc(), exp_instr()); end
            checks++; if (level !== 3'(q.size())) begin failures++; $display("FAIL rand_level n=%0d got=%0d exp=%0d", n, level, q.size()); end
            checks++; if (rom_addr !== 5'(m_pc)) begin failures++; $display("FAIL rand_rom_addr n=%0d got=%0d exp=%0d", n, rom_addr, m_pc); end
            checks++; if (stall_cnt !== 8'(m_stall) || flush_cnt !== 8'(m_flush)) begin failures++; $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_flush); end
        end
    endtask

    task automatic test_stats();
        do_reset(1);
        repeat (300) cycle(1'b0, 5'd0, 1'b0);
        repeat (3) cycle(1'b1, 5'($urandom), 1'b0);
        checks++; if (stall_cnt !== (STATS ? 8'd255 : 8'd0)) begin failures++; $display("FAIL stats_stall got=%0d exp=%0d", stall_cnt, STATS ? 255 : 0); end
        checks++; if (flush_cnt !== (STATS ? 8'd3 : 8'd0)) begin failures++; $display("FAIL stats_flush got=%0d exp=%0d", flush_cnt, STATS ? 3 : 0); end
        do_reset(1);
        checks++; if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0) begin failures++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'(i + 8'h10);
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_wrap();
        test_jump_full();
        test_reset_mid();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage between the program ROM and the instruction decoder.
- Owns the fetch program counter, drives the ROM address, and buffers fetched instructions with their PCs in a small FIFO.
- Presents the FIFO head to the decoder through a valid/ready handshake.
- Supports jump redirect with queue flush; replaces the free-running counter as the source of ROM addresses.

Parameters:
- ADDR_WIDTH, 5, width of fetch PC and ROM address.
- INSTR_WIDTH, 8, instruction word width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 0, fetch PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rom_addr  output  ADDR_WIDTH  ROM address; equals the fetch PC register.
- rom_data  input  INSTR_WIDTH  ROM read data; combinational from rom_addr in the same cycle.
- jump_en  input  1  redirect request; sampled at the rising edge.
- jump_target  input  ADDR_WIDTH  new fetch PC when jump_en=1.
- instr_ready  input  1  decoder accepts the head entry this cycle.
- instr_valid  output  1  head entry present (count != 0).
- instr  output  INSTR_WIDTH  head instruction; 0 when empty.
- instr_pc  output  ADDR_WIDTH  PC of the head instruction; 0 when empty.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- stall_cnt  output  8  stats, see Optional Feature.
- flush_cnt  output  8  stats, see Optional Feature.

Behaviour:
- Reset (rst=1 at an edge, overrides everything):
  - fetch_pc=RESET_PC, count=0, read/write pointers=0.
  - instr_valid=0, instr=0, instr_pc=0, level=0, stats=0.
  - Reset mid-operation discards all queued entries. No entry is pushed on the reset edge.
- Events per edge, when rst=0:
  - pop = instr_valid & instr_ready.
  - push = !jump_en & (count < DEPTH | pop).
- Push:
  - Writes {fetch_pc, rom_data} at the write pointer.
  - fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_WIDTH (all-ones -> 0, no other effect).
- Pop: advances the read pointer.
- Simultaneous push and pop:
  - count unchanged. This is allowed when full, so full plus continuous ready sustains 1 instruction/cycle.
- Full (count=DEPTH) without pop:
  - No push; fetch_pc holds; rom_addr holds.
- Empty:
  - instr_valid=0. instr_ready is ignored, so a pop on empty never underflows.
- Jump (jump_en=1 at edge N; highest priority after rst):
  - count<=0, pointers<=0, fetch_pc<=jump_target.
  - Any coincident pop or push is discarded; the decoder must not treat a head entry presented in a jump cycle as consumed.
  - Cycle after edge N: instr_valid=0, rom_addr=jump_target.
  - After edge N+1: instr_valid=1, instr=ROM[jump_target], instr_pc=jump_target.
  - A jump to the current fetch_pc still flushes.
- Steady state:
  - With ready held high and no jumps, one instruction per cycle with consecutive PCs.
  - First valid output appears one cycle after reset release.
- Outputs:
  - instr, instr_pc, instr_valid and level are combinational from FIFO state only.
  - They have no combinational path from instr_ready or jump_en.
  - rom_addr is registered.

Optional Feature:
- Macro IFQ_STATS_EN.
- Defined:
  - stall_cnt increments on every edge with instr_valid=1 & instr_ready=0 & !jump_en.
  - flush_cnt increments on every edge with jump_en=1.
  - Both saturate at 255 and clear on rst.
- Not defined: stall_cnt and flush_cnt are tied to 0 and no counter logic is built.

Test Plan:
- Reset release, ROM[i]=i+0x10, ready=1 -> valid from first cycle after reset, instr sequence 0x10,0x11,0x12…, instr_pc 0,1,2…, level stays ≤1.
- ready=0 for 10 cycles -> level climbs to 4 and holds; rom_addr frozen at 4. Then ready=1 -> PCs 0..7 delivered in order, none lost or duplicated.
- Fetch across wrap, RESET_PC=30 -> instr_pc 30,31,0,1, rom_addr wraps 31 -> 0.
- With queue full, jump_en=1, jump_target=9, ready=1 in the same cycle -> next cycle valid=0, level=0; following cycle instr_pc=9, instr=ROM[9].
- Assert rst for one cycle with level=3 -> level=0, valid=0, instr=0, rom_addr=RESET_PC; fetch restarts from RESET_PC.
- IFQ_STATS_EN defined, 300 stall cycles and 3 jumps -> stall_cnt=255, flush_cnt=3. Undefined -> both read 0.
